// File: rtl/network_driver_pkg.sv
// rtl/network_driver_pkg.sv - shared states, window default and no-spike code for network_driver
package network_driver_pkg;

  // Sequencing of one classification: collect frame, pulse start, watch window, hand back result.
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FIRE,
    RUN,
    REPORT
  } state_t;

  // Latency code reported when the window closed without any spike; sliced to WIDTH+1 bits by the user.
  localparam logic [31:0] NO_SPIKE_CODE = '1;

  // Full integration window for a WIDTH-bit accumulator.
  function automatic int default_window(input int width);
    return 2 ** (width + 1);
  endfunction

endpackage

// File: rtl/network_driver_if.sv
// rtl/network_driver_if.sv - pixel stream, network and result handshake bundle (res_count under NETWORK_DRIVER_SPIKE_COUNT_EN)
interface network_driver_if #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 7
);

  logic              bit_in;
  logic              bit_valid;
  logic              bit_ready;
  logic [HEIGHT-1:0] pixels;
  logic              start;
  logic [1:0]        neuron_out;
  logic              res_valid;
  logic              res_ready;
  logic              res_spiked;
  logic [WIDTH:0]    res_latency;
  logic              busy;
`ifdef NETWORK_DRIVER_SPIKE_COUNT_EN
  logic [WIDTH:0]    res_count;
`endif

  // Driver side.
  modport slave (
    input  bit_in, bit_valid, neuron_out, res_ready,
`ifdef NETWORK_DRIVER_SPIKE_COUNT_EN
    output res_count,
`endif
    output bit_ready, pixels, start, res_valid, res_spiked, res_latency, busy
  );

  // Host / network side.
  modport master (
    output bit_in, bit_valid, neuron_out, res_ready,
`ifdef NETWORK_DRIVER_SPIKE_COUNT_EN
    input  res_count,
`endif
    input  bit_ready, pixels, start, res_valid, res_spiked, res_latency, busy
  );

endinterface

// File: rtl/network_driver_pixel_deser.sv
// rtl/network_driver_pixel_deser.sv - serial pixel deserializer with write index and last-beat flag
module pixel_deser #(
  parameter int HEIGHT = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              wr_en,
  input  logic              bit_in,
  output logic [HEIGHT-1:0] pixels,
  output logic              last_beat
);

  localparam int IW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(HEIGHT - 1);

  logic [IW-1:0] index;

  assign last_beat = wr_en && (index == LAST_IDX);

  // Write each accepted bit at the current index; bits not yet rewritten keep the previous frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      index  <= '0;
      pixels <= '0;
    end else if (clear) begin
      index <= '0;
    end else if (wr_en) begin
      pixels[index] <= bit_in;
      index         <= last_beat ? '0 : index + IW'(1);
    end
  end

endmodule

// File: rtl/network_driver.sv
// rtl/network_driver.sv - frame load, start pulse, window watch and result handshake (optional NETWORK_DRIVER_SPIKE_COUNT_EN)
module network_driver
  import network_driver_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 7,
  parameter int WINDOW = default_window(WIDTH)
) (
  input logic            clk,
  input logic            rst,
  network_driver_if.slave bus
);

  localparam int CW = WIDTH + 1;
  localparam logic [CW-1:0] LAST_CYCLE = CW'(WINDOW - 1);

  state_t            state;
  state_t            state_next;
  logic [CW-1:0]     cnt;
  logic              spike_seen;
  logic [CW-1:0]     latency;
  logic              accepting;
  logic              beat;
  logic              last_beat;
  logic              deser_clear;
  logic [HEIGHT-1:0] frame;
  logic              unused_idle_flag;

  // The network's idle flag carries no information for the driver.
  assign unused_idle_flag = bus.neuron_out[1];

  assign accepting        = (state == IDLE) || (state == LOAD);
  assign beat             = bus.bit_valid && accepting;
  assign bus.bit_ready    = accepting;
  assign bus.pixels       = frame;
  assign bus.res_latency  = latency;
  assign bus.res_spiked   = (state == REPORT) && spike_seen;

  pixel_deser #(.HEIGHT(HEIGHT)) u_deser (
    .clk       (clk),
    .rst       (rst),
    .clear     (deser_clear),
    .wr_en     (beat),
    .bit_in    (bus.bit_in),
    .pixels    (frame),
    .last_beat (last_beat)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and per-state strobes.
  always_comb begin
    state_next    = state;
    bus.start     = 1'b0;
    bus.res_valid = 1'b0;
    bus.busy      = 1'b1;
    deser_clear   = 1'b0;
    unique case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (beat) state_next = last_beat ? FIRE : LOAD;
      end
      LOAD: begin
        if (beat && last_beat) state_next = FIRE;
      end
      FIRE: begin
        bus.start   = 1'b1;
        deser_clear = 1'b1;
        state_next  = RUN;
      end
      RUN: begin
        if (cnt == LAST_CYCLE) state_next = REPORT;
      end
      REPORT: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Window counter and first-spike capture; an empty window ends with the no-spike code.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      spike_seen <= 1'b0;
      latency    <= '0;
    end else begin
      case (state)
        FIRE: begin
          cnt        <= '0;
          spike_seen <= 1'b0;
        end
        RUN: begin
          if (cnt != LAST_CYCLE) cnt <= cnt + CW'(1);
          if (bus.neuron_out[0] && !spike_seen) begin
            spike_seen <= 1'b1;
            latency    <= cnt;
          end else if ((cnt == LAST_CYCLE) && !spike_seen) begin
            latency <= NO_SPIKE_CODE[CW-1:0];
          end
        end
        default: ;
      endcase
    end
  end

`ifdef NETWORK_DRIVER_SPIKE_COUNT_EN
  logic [CW-1:0] spike_cnt;

  assign bus.res_count = spike_cnt;

  // Saturating count of spiking RUN cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      spike_cnt <= '0;
    end else if (state == FIRE) begin
      spike_cnt <= '0;
    end else if ((state == RUN) && bus.neuron_out[0] && (spike_cnt != '1)) begin
      spike_cnt <= spike_cnt + CW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_network_driver.sv
// tb/tb_network_driver.sv - table-driven scoreboard bench for network_driver (honours NETWORK_DRIVER_SPIKE_COUNT_EN)
module tb_network_driver;
  import network_driver_pkg::*;

  localparam int WIDTH  = 8;
  localparam int HEIGHT = 7;
  localparam int WINDOW = default_window(WIDTH);

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  network_driver_if #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) bus ();

  network_driver #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [6:0] frame;
    int         spike_a;
    int         spike_b;
    int         gap;
    int         hold;
    logic       exp_spiked;
    logic [8:0] exp_latency;
    logic [8:0] exp_count;
  } vec_t;

  typedef struct {
    logic       spiked;
    logic [8:0] latency;
    logic [8:0] count;
    logic [6:0] frame;
  } exp_t;

  vec_t vecs[5];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic spiked, input logic [8:0] lat, input logic [8:0] cnt, input logic [6:0] f);
    exp_t e;
    e.spiked  = spiked;
    e.latency = lat;
    e.count   = cnt;
    e.frame   = f;
    sb.push_back(e);
  endtask

  task automatic send_frame(input logic [6:0] f, input int gap);
    for (int i = 0; i < HEIGHT; i++) begin
      for (int g = 0; g < gap; g++) begin
        bus.bit_valid = 1'b0;
        bus.bit_in    = ~f[i];
        @(negedge clk);
      end
      bus.bit_valid = 1'b1;
      bus.bit_in    = f[i];
      check("bit_ready while loading", 32'(bus.bit_ready), 32'd1);
      @(negedge clk);
    end
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
    check("start one cycle after last beat", 32'(bus.start), 32'd1);
    check("pixels at fire", 32'(bus.pixels), 32'(f));
  endtask

  // Entered on the FIRE negedge; neuron_out set at negedge k+1 is seen at counter value k.
  task automatic run_window(input int a, input int b, input int abort_at);
    for (int k = 0; k < WINDOW; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("start width", 32'(bus.start), 32'd0);
        check("busy in run", 32'(bus.busy), 32'd1);
        check("bit_ready in run", 32'(bus.bit_ready), 32'd0);
      end
      bus.neuron_out = {1'($urandom_range(0, 1)), ((k == a) || (k == b))};
      if (k == WINDOW - 1) check("res_valid before window end", 32'(bus.res_valid), 32'd0);
      if (k == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.neuron_out = 2'b00;
        check("abort start", 32'(bus.start), 32'd0);
        check("abort res_valid", 32'(bus.res_valid), 32'd0);
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort latency", 32'(bus.res_latency), 32'd0);
        check("abort bit_ready", 32'(bus.bit_ready), 32'd1);
        return;
      end
    end
    @(negedge clk);
    bus.neuron_out = 2'b00;
    check("res_valid at start+W+1", 32'(bus.res_valid), 32'd1);
  endtask

  task automatic finish_report(input int hold);
    exp_t e;
    check("scoreboard has entry", 32'(sb.size() > 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check("res_spiked", 32'(bus.res_spiked), 32'(e.spiked));
    check("res_latency", 32'(bus.res_latency), 32'(e.latency));
    check("pixels held", 32'(bus.pixels), 32'(e.frame));
`ifdef NETWORK_DRIVER_SPIKE_COUNT_EN
    check("res_count", 32'(bus.res_count), 32'(e.count));
`endif
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold res_valid", 32'(bus.res_valid), 32'd1);
      check("hold res_latency", 32'(bus.res_latency), 32'(e.latency));
      check("hold res_spiked", 32'(bus.res_spiked), 32'(e.spiked));
      check("hold bit_ready", 32'(bus.bit_ready), 32'd0);
    end
    bus.res_ready = 1'b1;
    bus.bit_valid = 1'b1;
    check("no accept on handshake cycle", 32'(bus.bit_ready), 32'd0);
    @(negedge clk);
    bus.res_ready = 1'b0;
    bus.bit_valid = 1'b0;
    check("idle res_valid", 32'(bus.res_valid), 32'd0);
    check("idle busy", 32'(bus.busy), 32'd0);
    check("idle bit_ready", 32'(bus.bit_ready), 32'd1);
    check("idle res_spiked", 32'(bus.res_spiked), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.bit_in     = 1'b0;
    bus.bit_valid  = 1'b0;
    bus.neuron_out = 2'b00;
    bus.res_ready  = 1'b0;
    rst            = 1'b1;

    vecs[0] = '{7'b1001101, 37,  90, 0, 0,  1'b1, 9'd37,  9'd2};
    vecs[1] = '{7'b0110010, -1,  -1, 0, 20, 1'b0, 9'h1FF, 9'd0};
    vecs[2] = '{7'b1111111, 0,  511, 1, 0,  1'b1, 9'd0,   9'd2};
    vecs[3] = '{7'b0000001, 511, -1, 0, 2,  1'b1, 9'd511, 9'd1};
    vecs[4] = '{7'b1010101, 5,    6, 2, 0,  1'b1, 9'd5,   9'd2};

    repeat (2) @(negedge clk);
    check("reset pixels", 32'(bus.pixels), 32'd0);
    check("reset start", 32'(bus.start), 32'd0);
    check("reset res_valid", 32'(bus.res_valid), 32'd0);
    check("reset res_spiked", 32'(bus.res_spiked), 32'd0);
    check("reset res_latency", 32'(bus.res_latency), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
`ifdef NETWORK_DRIVER_SPIKE_COUNT_EN
    check("reset res_count", 32'(bus.res_count), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    check("bit_ready after reset", 32'(bus.bit_ready), 32'd1);

    for (int v = 0; v < 5; v++) begin
      push_exp(vecs[v].exp_spiked, vecs[v].exp_latency, vecs[v].exp_count, vecs[v].frame);
      send_frame(vecs[v].frame, vecs[v].gap);
      run_window(vecs[v].spike_a, vecs[v].spike_b, -1);
      finish_report(vecs[v].hold);
    end

    // Gapped partial frame, then reset after the fourth bit.
    for (int i = 0; i < 4; i++) begin
      bus.bit_valid = 1'b0;
      @(negedge clk);
      bus.bit_valid = 1'b1;
      bus.bit_in    = 1'b1;
      @(negedge clk);
    end
    bus.bit_valid = 1'b0;
    check("partial frame busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("pixels cleared by reset", 32'(bus.pixels), 32'd0);
    check("busy cleared by reset", 32'(bus.busy), 32'd0);
    check("bit_ready after mid-load reset", 32'(bus.bit_ready), 32'd1);
    push_exp(1'b1, 9'd3, 9'd1, 7'b0000010);
    send_frame(7'b0000010, 1);
    run_window(3, -1, -1);
    finish_report(0);

    // Reset at RUN counter 200 discards the pending result; the next frame runs a full window.
    send_frame(7'b1100110, 0);
    run_window(50, -1, 200);
    check("pixels after run reset", 32'(bus.pixels), 32'd0);
    push_exp(1'b1, 9'd300, 9'd2, 7'b0011001);
    send_frame(7'b0011001, 0);
    run_window(300, 400, -1);
    finish_report(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
